cla16_adder: RTL and testbench

16-bit two-level carry-lookahead adder with a registered result. It computes S = A + B + Cin and carry-out Cout, and exposes block-level propagate/generate for cascading into wider adders. It is the final carry-propagate adder behind the Dadda and Wallace partial-product reduction trees, so it must be fast and hierarchical rather than ripple.

---
 rtl/cla16_adder.sv | 114 +++++++++++
 tb/tb_cla16_adder.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/cla16_adder.sv
// cla16_adder: 16-bit two-level carry-lookahead adder with a registered result.
// Bit-level propagate/generate feed four 4-bit lookahead groups. A second-level
// lookahead unit derives the group carry-ins from the group propagate/generate.
// Sum, carry-out and the block propagate/generate are captured in one output
// register stage. Every carry is a flat sum-of-products, so no carry ripples
// through more than one 4-bit group.
module cla16_adder (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    output logic [15:0] S,
    output logic        Cout,
    output logic        P,
    output logic        G
);

    // Bit-level propagate and generate, plus the carry into each bit position.
    logic [15:0] w_p;
    logic [15:0] w_g;
    logic [15:0] w_c;

    // Group propagate and generate, one pair per 4-bit group.
    logic [3:0]  w_pg;
    logic [3:0]  w_gg;

    // Group carry-ins: index 0 is Cin, then C4, C8, C12 and C16.
    logic [4:0]  w_gc;

    logic        w_blk_g;
    logic [15:0] w_sum;

    // Output register stage.
    logic [15:0] r_s;
    logic        r_cout;
    logic        r_p;
    logic        r_g;

    assign w_p = A ^ B;
    assign w_g = A & B;

    // First level: four 4-bit lookahead groups. Inside a group, each carry is
    // expanded from the group carry-in, so no carry ripples from bit to bit.
    for (genvar k = 0; k < 4; k++) begin : g_group
        localparam int LSB = 4 * k;

        assign w_pg[k] = w_p[LSB+3] & w_p[LSB+2] & w_p[LSB+1] & w_p[LSB];

        assign w_gg[k] = w_g[LSB+3]
                       | (w_p[LSB+3] & w_g[LSB+2])
                       | (w_p[LSB+3] & w_p[LSB+2] & w_g[LSB+1])
                       | (w_p[LSB+3] & w_p[LSB+2] & w_p[LSB+1] & w_g[LSB]);

        assign w_c[LSB]   = w_gc[k];
        assign w_c[LSB+1] = w_g[LSB]
                          | (w_p[LSB] & w_gc[k]);
        assign w_c[LSB+2] = w_g[LSB+1]
                          | (w_p[LSB+1] & w_g[LSB])
                          | (w_p[LSB+1] & w_p[LSB] & w_gc[k]);
        assign w_c[LSB+3] = w_g[LSB+2]
                          | (w_p[LSB+2] & w_g[LSB+1])
                          | (w_p[LSB+2] & w_p[LSB+1] & w_g[LSB])
                          | (w_p[LSB+2] & w_p[LSB+1] & w_p[LSB] & w_gc[k]);
    end

    // Second level: lookahead unit. It computes every group carry-in directly
    // from the group propagate/generate and Cin.
    assign w_gc[0] = Cin;
    assign w_gc[1] = w_gg[0]
                   | (w_pg[0] & Cin);
    assign w_gc[2] = w_gg[1]
                   | (w_pg[1] & w_gg[0])
                   | (w_pg[1] & w_pg[0] & Cin);
    assign w_gc[3] = w_gg[2]
                   | (w_pg[2] & w_gg[1])
                   | (w_pg[2] & w_pg[1] & w_gg[0])
                   | (w_pg[2] & w_pg[1] & w_pg[0] & Cin);
    assign w_gc[4] = w_blk_g
                   | (w_pg[3] & w_pg[2] & w_pg[1] & w_pg[0] & Cin);

    // Block generate is the carry-out with the Cin term removed. This is what a
    // wider adder's lookahead unit needs when it cascades this block.
    assign w_blk_g = w_gg[3]
                   | (w_pg[3] & w_gg[2])
                   | (w_pg[3] & w_pg[2] & w_gg[1])
                   | (w_pg[3] & w_pg[2] & w_pg[1] & w_gg[0]);

    assign w_sum = w_p ^ w_c;

    // Capture the result on each edge. Reset clears the outputs and takes
    // priority over the operands.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments, so every register in this block
        // samples the values that were present before the clock edge.
        if (rst) begin
            r_s    <= 16'h0000;
            r_cout <= 1'b0;
            r_p    <= 1'b0;
            r_g    <= 1'b0;
        end else begin
            r_s    <= w_sum;
            r_cout <= w_gc[4];
            r_p    <= w_pg[3] & w_pg[2] & w_pg[1] & w_pg[0];
            r_g    <= w_blk_g;
        end
    end

    assign S    = r_s;
    assign Cout = r_cout;
    assign P    = r_p;
    assign G    = r_g;

endmodule

// File: tb/tb_cla16_adder.sv
// tb_cla16_adder: scoreboard bench for cla16_adder. The driver applies one
// operand set per cycle and queues the expected response. A monitor pops one
// entry per cycle and compares it with the registered outputs.
module tb_cla16_adder;

    logic        clk;
    logic        rst;
    logic [15:0] A;
    logic [15:0] B;
    logic        Cin;
    logic [15:0] S;
    logic        Cout;
    logic        P;
    logic        G;

    typedef struct {
        logic [15:0] s;
        logic        cout;
        logic        p;
        logic        g;
        string       tag;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    cla16_adder dut (
        .clk  (clk),
        .rst  (rst),
        .A    (A),
        .B    (B),
        .Cin  (Cin),
        .S    (S),
        .Cout (Cout),
        .P    (P),
        .G    (G)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [18:0] act, input logic [18:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got {Cout,S,P,G}=%h_%h_%b_%b, expected %h_%h_%b_%b",
                     name, act[18], act[17:2], act[1], act[0],
                     req[18], req[17:2], req[1], req[0]);
        end
    endtask

    // Reference model: plain unsigned arithmetic on the operands.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic r, input string tag);
        exp_t        e;
        logic [16:0] full;
        logic [16:0] no_cin;
        full   = {1'b0, a} + {1'b0, b} + {16'b0, cin};
        no_cin = {1'b0, a} + {1'b0, b};
        e.tag  = tag;
        if (r) begin
            e.s    = 16'h0000;
            e.cout = 1'b0;
            e.p    = 1'b0;
            e.g    = 1'b0;
        end else begin
            e.s    = full[15:0];
            e.cout = full[16];
            e.p    = &(a ^ b);
            e.g    = no_cin[16];
        end
        return e;
    endfunction

    // Drive one operand set away from the sampling edge and queue its expectation.
    task automatic drive(input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic r, input string tag);
        @(negedge clk);
        A   = a;
        B   = b;
        Cin = cin;
        rst = r;
        exp_q.push_back(model(a, b, cin, r, tag));
    endtask

    // Monitor: one result per cycle, sampled just after the rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check(e.tag, {Cout, S, P, G}, {e.cout, e.s, e.p, e.g});
            end
        end
    end

    initial begin
        int waited;
        rst = 1'b1;
        A   = 16'h0000;
        B   = 16'h0000;
        Cin = 1'b0;

        // Reset with all-ones operands must still give zero outputs.
        drive(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, "reset0");
        drive(16'hFFFF, 16'hFFFF, 1'b1, 1'b1, "reset1");
        drive(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, "post_reset");

        drive(16'd125,  16'd150,  1'b0, 1'b0, "basic_add");
        drive(16'hFFFF, 16'h0000, 1'b1, 1'b0, "full_prop_cin1");
        drive(16'hFFFF, 16'h0000, 1'b0, 1'b0, "full_prop_cin0");
        drive(16'h8000, 16'h8000, 1'b0, 1'b0, "msb_generate");
        drive(16'h00FF, 16'h0001, 1'b0, 1'b0, "group_boundary");
        drive(16'h0FFF, 16'h0001, 1'b0, 1'b0, "group_boundary_12");
        drive(16'h000F, 16'h0000, 1'b1, 1'b0, "group_boundary_4");

        // Back-to-back operands on consecutive cycles.
        drive(16'h0001, 16'h0002, 1'b0, 1'b0, "b2b_0");
        drive(16'hFFFF, 16'h0001, 1'b0, 1'b0, "b2b_1");
        drive(16'h1234, 16'h4321, 1'b1, 1'b0, "b2b_2");

        // Random vectors with a two-cycle reset pulse in the middle.
        for (int i = 0; i < 10000; i++) begin
            drive(16'($urandom), 16'($urandom), 1'($urandom),
                  (i == 5000 || i == 5001) ? 1'b1 : 1'b0, "random");
        end

        // Give the monitor a bounded window to consume the last expectations.
        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            #2;
            waited++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
